// File: rtl/i2c_pkg.sv
// Shared I2C timing types and 50 MHz default quarter-period divisors.
package i2c_pkg;

  typedef enum logic [1:0] {SPD_STD, SPD_FAST, SPD_FPLUS} speed_t;
  typedef enum logic [1:0] {PH_Q0, PH_Q1, PH_Q2, PH_Q3} phase_t;

  localparam int unsigned DEF_CLK_FREQ_HZ = 50_000_000;
  localparam int unsigned DEF_QDIV_STD    = DEF_CLK_FREQ_HZ / 400_000;
  localparam int unsigned DEF_QDIV_FAST   = DEF_CLK_FREQ_HZ / 1_600_000;
  localparam int unsigned DEF_QDIV_FPLUS  = DEF_CLK_FREQ_HZ / 4_000_000;
  localparam int unsigned DEF_CNT_W       = 16;

  // Reserved encoding 11 falls back to standard mode.
  function automatic speed_t decode_speed(input logic [1:0] sel);
    case (sel)
      2'b01:   return SPD_FAST;
      2'b10:   return SPD_FPLUS;
      default: return SPD_STD;
    endcase
  endfunction

endpackage

// File: rtl/i2c_sync2.sv
// Two-flop synchroniser for the raw SCL pad; resets to the released (high) level.
module i2c_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q_early,
  output logic q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q_early <= 1'b1;
      q       <= 1'b1;
    end else begin
      q_early <= d;
      q       <= q_early;
    end
  end

endmodule

// File: rtl/i2c_scl_timing_gen.sv
// Multi-speed I2C SCL quarter-phase timing generator with registered strobes.
// Clock stretching is enabled by defining I2C_CLK_STRETCH_EN.
module i2c_scl_timing_gen
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
  parameter int unsigned QDIV_STD    = CLK_FREQ_HZ / 400_000,
  parameter int unsigned QDIV_FAST   = CLK_FREQ_HZ / 1_600_000,
  parameter int unsigned QDIV_FPLUS  = CLK_FREQ_HZ / 4_000_000,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic       ref_clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] speed_sel,
  input  logic       scl_in,
  output logic       scl_oe,
  output logic       busy,
  output logic [1:0] phase,
  output logic       change_tick,
  output logic       sample_tick,
  output logic       period_tick,
  output logic       stretch
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_q, state_n;
  phase_t           phase_q, phase_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [CNT_W-1:0] qdiv_q, qdiv_n;
  logic [CNT_W-1:0] sel_qdiv;
  logic             run_n, last_n;
  logic             hold;
  logic             scl_early;

`ifdef I2C_CLK_STRETCH_EN
  logic scl_s;

  i2c_sync2 u_sync (
    .clk     (ref_clk),
    .reset   (reset),
    .d       (scl_in),
    .q_early (scl_early),
    .q       (scl_s)
  );

  assign hold = (state_q == ST_RUN) && (phase_q == PH_Q2) && !scl_s;
`else
  logic unused_scl_in;

  assign unused_scl_in = scl_in;
  assign scl_early     = 1'b1;
  assign hold          = 1'b0;
`endif

  always_comb begin
    case (decode_speed(speed_sel))
      SPD_FAST:  sel_qdiv = CNT_W'(QDIV_FAST);
      SPD_FPLUS: sel_qdiv = CNT_W'(QDIV_FPLUS);
      default:   sel_qdiv = CNT_W'(QDIV_STD);
    endcase
  end

  always_comb begin
    state_n = state_q;
    phase_n = phase_q;
    cnt_n   = cnt_q;
    qdiv_n  = qdiv_q;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_n = ST_RUN;
          phase_n = PH_Q0;
          cnt_n   = '0;
          qdiv_n  = sel_qdiv;
        end
      end
      ST_RUN: begin
        if (!hold) begin
          if (cnt_q == qdiv_q - ONE) begin
            cnt_n = '0;
            if (phase_q == PH_Q3) begin
              phase_n = PH_Q0;
              if (en) qdiv_n = sel_qdiv;
              else    state_n = ST_IDLE;
            end else begin
              phase_n = phase_t'(phase_q + 2'd1);
            end
          end else begin
            cnt_n = cnt_q + ONE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign run_n  = (state_n == ST_RUN);
  assign last_n = (cnt_n == qdiv_n - ONE);

  // Outputs are computed from next state so each strobe lands on the cycle it names;
  // the early sync stage predicts whether the next Q2 cycle will be held.
  always_ff @(posedge ref_clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      phase_q     <= PH_Q0;
      cnt_q       <= '0;
      qdiv_q      <= CNT_W'(QDIV_STD);
      scl_oe      <= 1'b0;
      change_tick <= 1'b0;
      sample_tick <= 1'b0;
      period_tick <= 1'b0;
      stretch     <= 1'b0;
    end else begin
      state_q     <= state_n;
      phase_q     <= phase_n;
      cnt_q       <= cnt_n;
      qdiv_q      <= qdiv_n;
      scl_oe      <= run_n && (phase_n == PH_Q0 || phase_n == PH_Q1);
      change_tick <= run_n && (phase_n == PH_Q0) && last_n;
      sample_tick <= run_n && (phase_n == PH_Q2) && last_n && scl_early;
      period_tick <= run_n && (phase_n == PH_Q3) && last_n;
      stretch     <= run_n && (phase_n == PH_Q2) && !scl_early;
    end
  end

  assign busy  = (state_q == ST_RUN);
  assign phase = phase_q;

endmodule

// File: tb/tb_i2c_scl_timing_gen.sv
// Self-checking bench for i2c_scl_timing_gen: position-in-period model plus directed timing checks.
module tb_i2c_scl_timing_gen;

`ifdef I2C_CLK_STRETCH_EN
  localparam bit STRETCH    = 1'b1;
  localparam int SYNC_EXTRA = 2;
`else
  localparam bit STRETCH    = 1'b0;
  localparam int SYNC_EXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       reset, en, slave;
  logic [1:0] speed_sel;
  logic       scl_in;
  logic       scl_oe, busy, change_tick, sample_tick, period_tick, stretch;
  logic [1:0] phase;

  assign scl_in = ~scl_oe & slave;

  i2c_scl_timing_gen #(
    .CLK_FREQ_HZ (50_000_000),
    .QDIV_STD    (125),
    .QDIV_FAST   (31),
    .QDIV_FPLUS  (12),
    .CNT_W       (16)
  ) dut (
    .ref_clk     (clk),
    .reset       (reset),
    .en          (en),
    .speed_sel   (speed_sel),
    .scl_in      (scl_in),
    .scl_oe      (scl_oe),
    .busy        (busy),
    .phase       (phase),
    .change_tick (change_tick),
    .sample_tick (sample_tick),
    .period_tick (period_tick),
    .stretch     (stretch)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit chk_on = 1'b0;

  // Model: position within the period, quarter size, and the last two sampled SCL line levels.
  int m_run = 0;
  int m_pos = 0;
  int m_q = 125;
  bit h1 = 1'b1;
  bit h2 = 1'b1;
  bit m_line, m_hold, m_in_q2;

  function automatic int qd(input logic [1:0] s);
    case (s)
      2'b01:   return 31;
      2'b10:   return 12;
      default: return 125;
    endcase
  endfunction

  always @(posedge clk) begin
    m_line  = !(m_run != 0 && m_pos < 2 * m_q) && slave;
    m_in_q2 = m_run != 0 && m_pos >= 2 * m_q && m_pos < 3 * m_q;
    if (reset) begin
      m_run = 0;
      m_pos = 0;
      h1    = 1'b1;
      h2    = 1'b1;
    end else begin
      m_hold = STRETCH && m_in_q2 && !h2;
      if (m_run == 0) begin
        if (en) begin
          m_run = 1;
          m_pos = 0;
          m_q   = qd(speed_sel);
        end
      end else if (m_hold) begin
        m_pos = m_pos;
      end else if (m_pos == 4 * m_q - 1) begin
        m_pos = 0;
        if (en) m_q = qd(speed_sel);
        else    m_run = 0;
      end else begin
        m_pos = m_pos + 1;
      end
      h2 = h1;
      h1 = m_line;
    end
  end

  logic [7:0] e_v, a_v;
  logic [1:0] e_phase;
  bit         e_st, e_q2;

  always @(negedge clk) begin
    if (chk_on) begin
      e_q2    = m_run != 0 && m_pos >= 2 * m_q && m_pos < 3 * m_q;
      e_st    = STRETCH && e_q2 && !h2;
      e_phase = 2'(m_pos / m_q);
      e_v = {m_run != 0, e_phase, m_run != 0 && m_pos < 2 * m_q,
             m_run != 0 && m_pos == m_q - 1,
             m_run != 0 && m_pos == 3 * m_q - 1 && !e_st,
             m_run != 0 && m_pos == 4 * m_q - 1, e_st};
      a_v = {busy, phase, scl_oe, change_tick, sample_tick, period_tick, stretch};
      if (m_run == 0) begin
        e_v[6:5] = 2'b00; e_v[0] = 1'b0;
        a_v[6:5] = 2'b00; a_v[0] = 1'b0;
      end
      n_total++;
      if (a_v == e_v) n_pass++;
      else $display("FAIL cycle_model t=%0t got busy/ph/oe/ch/sa/pe/st=%b expected %b", $time, a_v, e_v);
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  int r_len, r_ch, r_sa, r_oe, r_st, r_nch, r_nsa;

  // Follows one period from its first cycle; inputs may be changed at given cycle numbers.
  task automatic track(input int maxc, input int drop_at, input int sel_at,
                       input logic [1:0] new_sel, input int slo_at, input int shi_at);
    r_len = 0; r_ch = 0; r_sa = 0; r_oe = 0; r_st = 0; r_nch = 0; r_nsa = 0;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if (scl_oe) r_oe++;
      if (stretch) r_st++;
      if (change_tick) begin r_nch++; if (r_ch == 0) r_ch = i; end
      if (sample_tick) begin r_nsa++; if (r_sa == 0) r_sa = i; end
      if (i == drop_at) en = 1'b0;
      if (i == sel_at) speed_sel = new_sel;
      if (i == slo_at) slave = 1'b0;
      if (i == shi_at) slave = 1'b1;
      if (period_tick) begin
        r_len = i;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; en = 1'b0; speed_sel = 2'b00; slave = 1'b1;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    check("rst_busy", int'(busy), 0);
    check("rst_oe", int'(scl_oe), 0);
    check("rst_ticks", int'(change_tick) + int'(sample_tick) + int'(period_tick), 0);

    // First standard period from idle
    reset = 1'b0;
    @(negedge clk);
    en = 1'b1; speed_sel = 2'b00;
    track(700, -1, -1, 2'b00, -1, -1);
    check("t1_period", r_len, 500 + SYNC_EXTRA);
    check("t1_change", r_ch, 125);
    check("t1_sample", r_sa, 375 + SYNC_EXTRA);
    check("t1_oe_cycles", r_oe, 250);

    // Three periods back to back, en dropped mid-Q1 of the fourth
    track(700, -1, -1, 2'b00, -1, -1);
    check("t2_period2", r_len, 500 + SYNC_EXTRA);
    track(700, -1, -1, 2'b00, -1, -1);
    check("t2_period3", r_len, 500 + SYNC_EXTRA);
    track(700, 200, -1, 2'b00, -1, -1);
    check("t2_period4", r_len, 500 + SYNC_EXTRA);
    @(negedge clk);
    check("t2_idle_busy", int'(busy), 0);
    check("t2_idle_oe", int'(scl_oe), 0);

    // Speed change mid-Q2 only affects the following period
    en = 1'b1; speed_sel = 2'b00;
    track(700, -1, 300, 2'b01, -1, -1);
    check("t3_cur_period", r_len, 500 + SYNC_EXTRA);
    track(300, 10, -1, 2'b01, -1, -1);
    check("t3_fast_period", r_len, 124 + SYNC_EXTRA);
    check("t3_fast_change", r_ch, 31);
    @(negedge clk);
    check("t3_idle_busy", int'(busy), 0);

    // Reset during Q1 aborts the period
    en = 1'b1; speed_sel = 2'b00;
    repeat (200) @(negedge clk);
    check("t4_oe_in_q1", int'(scl_oe), 1);
    reset = 1'b1;
    @(negedge clk);
    check("t4_rst_busy", int'(busy), 0);
    check("t4_rst_oe", int'(scl_oe), 0);
    check("t4_rst_ticks", int'(change_tick) + int'(sample_tick) + int'(period_tick), 0);
    reset = 1'b0;
    track(700, -1, 10, 2'b10, -1, -1);
    check("t4_restart_period", r_len, 500 + SYNC_EXTRA);
    check("t4_restart_change", r_ch, 125);

    // Fast-plus period, one strobe of each kind
    track(200, 5, -1, 2'b10, -1, -1);
    check("t6_fplus_period", r_len, 48 + SYNC_EXTRA);
    check("t6_fplus_nchange", r_nch, 1);
    check("t6_fplus_nsample", r_nsa, 1);
    @(negedge clk);

`ifdef I2C_CLK_STRETCH_EN
    // Slave holds the line low for the first 40 cycles of Q2
    en = 1'b1; speed_sel = 2'b00;
    track(900, 100, -1, 2'b00, 240, 290);
    check("t5_period", r_len, 542);
    check("t5_stretch_cycles", r_st, 42);
    check("t5_sample", r_sa, 417);
    @(negedge clk);
`endif

    repeat (5) @(negedge clk);
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
